// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed seven-segment scanner with double-buffered data
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS       = 8,
  parameter int DIV_WIDTH        = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    enable,
  input  logic [DIV_WIDTH-1:0]    div_val,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic                    data_load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

  // Active-low font, seg[6]=a ... seg[0]=g.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'b0000001;
      4'h1: hex_font = 7'b1001111;
      4'h2: hex_font = 7'b0010010;
      4'h3: hex_font = 7'b0000110;
      4'h4: hex_font = 7'b1001100;
      4'h5: hex_font = 7'b0100100;
      4'h6: hex_font = 7'b0100000;
      4'h7: hex_font = 7'b0001111;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0000100;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b1100000;
      4'hC: hex_font = 7'b0110001;
      4'hD: hex_font = 7'b1000010;
      4'hE: hex_font = 7'b0110000;
      default: hex_font = 7'b0111000;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic [DW-1:0]         active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic [NUM_DIGITS-1:0] active_blank_q, active_blank_d;
  logic                  pending_q, pending_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap_tick;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [3:0]            nib;
  logic                  dark;
  logic [NUM_DIGITS-1:0] an_low;
  logic [6:0]            seg_low;
  logic                  dp_low;

  // Prescaler and digit index; disabled scanning parks both at zero.
  always_comb begin
    tick      = 1'b0;
    wrap_tick = 1'b0;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (enable) begin
      tick = (cnt_q >= div_val);
      if (tick) begin
        cnt_d     = '0;
        wrap_tick = (idx_q == LAST_IDX);
        idx_d     = wrap_tick ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end
    wrap_d = wrap_tick;
  end

  // Shadow/active buffers: new data only reaches the display at a frame wrap.
  always_comb begin
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    active_blank_d = active_blank_q;
    pending_d      = pending_q;
    if (wrap_tick && pending_q) begin
      active_data_d  = shadow_data_q;
      active_dp_d    = shadow_dp_q;
      active_blank_d = shadow_blank_q;
      pending_d      = 1'b0;
    end
    if (data_load) begin
      shadow_data_d  = data_in;
      shadow_dp_d    = dp_in;
      shadow_blank_d = blank_in;
      pending_d      = 1'b1;
    end
  end

  // Leading-zero mask: a digit is suppressed when it and all higher nibbles are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_data_q[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_suppress && zero_above && (i != 0);
    end
  end

  // Output decode from the current index, built active-low then polarity-adjusted.
  always_comb begin
    nib     = 4'(active_data_q >> {idx_q, 2'b00});
    dark    = active_blank_q[idx_q] | lz_dark[idx_q];
    an_low  = ~(NUM_DIGITS'(1) << idx_q);
    seg_low = dark ? 7'h7F : hex_font(nib);
    dp_low  = dark ? 1'b1 : ~active_dp_q[idx_q];
    frame_done_d = enable & wrap_q;
    if (!enable) begin
      an_low  = {NUM_DIGITS{1'b1}};
      seg_low = 7'h7F;
      dp_low  = 1'b1;
    end
    an_d  = ANODE_ACTIVE_LOW ? an_low : ~an_low;
    seg_d = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
    dp_d  = SEG_ACTIVE_LOW ? dp_low : ~dp_low;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      active_blank_q <= '0;
      pending_q      <= 1'b0;
      wrap_q         <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      active_blank_q <= active_blank_d;
      pending_q      <= pending_d;
      wrap_q         <= wrap_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - self-checking bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

  typedef struct {
    int          at;
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
  } ld_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] div_val = 16'd3;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        lz_suppress = 1'b0;
  logic        data_load = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model: what is on screen, what waits in the shadow buffer.
  logic [31:0] m_data, s_data;
  logic [7:0]  m_dp, s_dp, m_blank, s_blank;
  bit          m_pend;

  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  ld_t no_ld = '{-1, 32'h0, 8'h0, 8'h0};

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(8), .DIV_WIDTH(16), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .Rst(Rst), .enable(enable), .div_val(div_val), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_suppress(lz_suppress), .data_load(data_load),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_digit(input int d, output logic [6:0] s, output logic p);
    logic [31:0] above;
    bit          is_dark;
    above   = m_data >> (4 * d);
    is_dark = m_blank[d] || (lz_suppress && d != 0 && above == 0);
    if (is_dark) begin
      s = 7'h7F;
      p = 1'b1;
    end else begin
      s = font[above & 32'hF];
      p = ~m_dp[d];
    end
  endfunction

  task automatic model_reset();
    m_data = '0; m_dp = '0; m_blank = '0;
    s_data = '0; s_dp = '0; s_blank = '0;
    m_pend = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (frame_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: frame_done never seen, required a pulse within 200 cycles", name);
    end
  endtask

  // Called at the negedge where a frame's digit 0 first appears; checks 32 cycles (div_val=3).
  task automatic check_frame(input string name, input bit fd_first, input ld_t l1, input ld_t l2);
    logic [7:0] ea;
    logic [6:0] es;
    logic       ep, ef;
    for (int c = 0; c < 32; c++) begin
      ea = ~(8'd1 << (c / 4));
      model_digit(c / 4, es, ep);
      ef = (c == 0) ? fd_first : 1'b0;
      checks++;
      if ({an, seg, dp, frame_done} !== {ea, es, ep, ef}) begin
        errors++;
        $display("FAIL %s cycle %0d: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                 name, c, an, seg, dp, frame_done, ea, es, ep, ef);
      end
      data_load = 1'b0;
      if (c == l1.at || c == l2.at) begin
        ld_t l;
        l = (c == l1.at) ? l1 : l2;
        data_in = l.d; dp_in = l.p; blank_in = l.b; data_load = 1'b1;
        if (c < 30) begin
          s_data = l.d; s_dp = l.p; s_blank = l.b; m_pend = 1'b1;
        end
      end
      @(negedge clk);
    end
    data_load = 1'b0;
    if (m_pend) begin
      m_data = s_data; m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
    end
    if (l1.at >= 30 || l2.at >= 30) begin
      ld_t l;
      l = (l1.at >= 30) ? l1 : l2;
      s_data = l.d; s_dp = l.p; s_blank = l.b; m_pend = 1'b1;
    end
  endtask

  task automatic check_dark(input string name);
    checks++;
    if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: an=%b seg=%b dp=%b fd=%b, required an=11111111 seg=1111111 dp=1 fd=0",
               name, an, seg, dp, frame_done);
    end
  endtask

  task automatic test_reset();
    model_reset();
    Rst = 1'b1; enable = 1'b1; div_val = 16'd3; lz_suppress = 1'b0;
    data_in = $urandom; dp_in = 8'($urandom); blank_in = 8'h00; data_load = 1'b1;
    @(negedge clk); @(negedge clk);
    check_dark("reset_outputs");
    Rst = 1'b0; data_load = 1'b0;
  endtask

  task automatic test_scan();
    wait_frame("scan_first_wrap");
    check_frame("scan_zeros_f0", 1'b1, no_ld, no_ld);
    check_frame("scan_zeros_f1", 1'b1, no_ld, no_ld);
  endtask

  task automatic test_data_load();
    ld_t l = '{10, 32'h0123ABCF, 8'h01, 8'h00};
    check_frame("load_old_frame", 1'b1, l, no_ld);
    check_frame("load_new_frame", 1'b1, no_ld, no_ld);
  endtask

  task automatic test_lz();
    ld_t l50 = '{5, 32'h00000050, 8'h00, 8'h00};
    ld_t l0  = '{20, 32'h00000000, 8'h00, 8'h00};
    lz_suppress = 1'b1;
    check_frame("lz_load50", 1'b1, l50, no_ld);
    check_frame("lz_show50", 1'b1, l0, no_ld);
    check_frame("lz_show0", 1'b1, no_ld, no_ld);
    lz_suppress = 1'b0;
  endtask

  task automatic test_blank();
    ld_t l = '{3, 32'h88888888, 8'hFF, 8'h80};
    check_frame("blank_load", 1'b1, l, no_ld);
    check_frame("blank_show", 1'b1, no_ld, no_ld);
  endtask

  task automatic test_load_on_wrap();
    ld_t la = '{10, 32'hA5A5A5A5, 8'h0F, 8'h00};
    ld_t lb = '{30, 32'h5A5A5A5A, 8'hF0, 8'h00};
    check_frame("wrap_load_f0", 1'b1, la, lb);
    check_frame("wrap_prior_shadow", 1'b1, no_ld, no_ld);
    check_frame("wrap_new_value", 1'b1, no_ld, no_ld);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      ld_t l;
      l.at = int'($urandom_range(0, 30));
      l.d  = $urandom >> $urandom_range(0, 31);
      l.p  = 8'($urandom);
      l.b  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      lz_suppress = 1'($urandom);
      check_frame($sformatf("random_%0d", i), 1'b1, l, no_ld);
    end
    lz_suppress = 1'b0;
    check_frame("random_tail", 1'b1, no_ld, no_ld);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 9; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_load = (i == 2);
      if (i == 2) begin
        data_in = 32'hFEDC0042; dp_in = 8'h81; blank_in = 8'h00;
        s_data = data_in; s_dp = dp_in; s_blank = blank_in; m_pend = 1'b1;
      end
      check_dark($sformatf("disabled_%0d", i));
    end
    data_load = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check_frame("reenable_frame", 1'b0, no_ld, no_ld);
    check_frame("reenable_new_data", 1'b1, no_ld, no_ld);
  endtask

  task automatic check_an(input string name, input int digit);
    logic [7:0] ea;
    ea = ~(8'd1 << digit);
    checks++;
    if (an !== ea) begin
      errors++;
      $display("FAIL %s: an=%b, required %b", name, an, ea);
    end
  endtask

  task automatic test_div_shrink_reset();
    Rst = 1'b1; div_val = 16'd100;
    @(negedge clk);
    Rst = 1'b0;
    model_reset();
    for (int m = 1; m <= 50; m++) begin
      @(negedge clk);
      if (m == 1) check_an("div100_first", 0);
    end
    div_val = 16'd2;
    @(negedge clk);
    check_an("shrink_before_tick", 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_an($sformatf("shrink_period_%0d", k), 1 + k / 3);
    end
    data_in = 32'h12345678; dp_in = 8'hFF; data_load = 1'b1;
    @(negedge clk);
    data_load = 1'b0;
    Rst = 1'b1;
    @(negedge clk);
    check_dark("mid_frame_reset");
    Rst = 1'b0; div_val = 16'd3;
    wait_frame("after_reset_wrap");
    check_frame("after_reset_f0", 1'b1, no_ld, no_ld);
    check_frame("after_reset_f1", 1'b1, '{12, 32'h0, 8'h00, 8'h00}, no_ld);
    check_frame("after_reload", 1'b1, no_ld, no_ld);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_data_load();
    test_lz();
    test_blank();
    test_load_on_wrap();
    test_random();
    test_enable();
    test_div_shrink_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 8-digit, fixed-divider scanner in the top level. It adds:
- digit count, prescaler and output polarity set by parameter;
- runtime refresh divider;
- double-buffered (tear-free) data update;
- per-digit blanking and decimal points;
- leading-zero suppression;
- a frame-done strobe.

It sits on the mmio_bus display path and drives the board anode and segment pins directly.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16); the display word is 4*NUM_DIGITS bits.
DIV_WIDTH, 16, width of the prescaler counter and of div_val.
ANODE_ACTIVE_LOW, 1, 1 = an[] is driven low for the selected digit.
SEG_ACTIVE_LOW, 1, 1 = seg/dp are driven low for a lit segment.

Ports:
clk  in  1  system clock; the only clock in the block.
Rst  in  1  synchronous, active-high reset.
enable  in  1  1 = scanning runs; 0 = display dark and scan index held at 0.
div_val  in  DIV_WIDTH  prescaler terminal count; the scan advances every div_val+1 cycles.
data_in  in  4*NUM_DIGITS  hex nibbles; digit i = data_in[4i+3:4i].
dp_in  in  NUM_DIGITS  decimal-point enables, one per digit.
blank_in  in  NUM_DIGITS  1 = force digit i dark.
lz_suppress  in  1  1 = blank leading zero digits.
data_load  in  1  one-cycle strobe; captures data_in, dp_in and blank_in into the shadow buffer.
an  out  NUM_DIGITS  digit anodes; one-hot active while scanning.
seg  out  7  segments; seg[6]=a ... seg[0]=g.
dp  out  1  decimal point.
frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset, synchronous, active-high, Rst dominant over all other inputs:
  - prescaler = 0, digit index = 0;
  - shadow and active buffers = 0; pending = 0;
  - an = all inactive; seg and dp = off; frame_done = 0.
- Prescaler: counts 0..div_val.
  - tick = (cnt >= div_val); on tick, cnt <= 0, else cnt <= cnt+1.
  - The >= comparison makes a div_val that shrinks below cnt take effect at once.
  - div_val = 0 gives a tick every cycle.
- On tick: index <= (index == NUM_DIGITS-1) ? 0 : index+1.
  - The wrap also asserts frame_done on the following cycle, registered with the outputs.
- Double buffering:
  - data_load copies the inputs into shadow and sets pending.
  - On the wrap tick with pending = 1: active <= shadow and pending <= 0, unless data_load is also asserted that cycle.
  - If data_load coincides with the wrap tick: active takes the pre-cycle shadow, shadow takes the new data, and pending stays 1.
  - Displayed data therefore changes only at frame boundaries.
- Outputs are registered and are valid the cycle after index changes. Output latency = 1 cycle from index.
- Lit digit i:
  - an one-hot at bit i;
  - seg = hex font of active nibble i;
  - dp = active dp bit i.
- Digit i is dark (an still asserted, seg and dp off) when either:
  - active blank bit i = 1; or
  - lz_suppress = 1, nibble i = 0, and every higher nibble is 0.
  - Digit 0 is never zero-suppressed. It can still be blanked by blank_in.
- Hex font, active-low seg[6:0]:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - SEG_ACTIVE_LOW = 0 inverts seg and dp.
  - ANODE_ACTIVE_LOW = 0 inverts an.
- enable = 0:
  - next cycle: an all inactive, seg and dp off;
  - index and prescaler are cleared and held;
  - data_load, shadow and pending still operate, and pending is retained;
  - re-enable starts at digit 0 after a full div_val+1 period.
- Rst mid-frame discards pending shadow data.

Test Plan:
- NUM_DIGITS=8, div_val=3, enable=1 after reset -> an steps through 11111110, 11111101, ... with 4 cycles per digit; frame_done pulses once every 32 cycles, on the first cycle an returns to 11111110.
- Load data_in=32'h0123ABCF, dp_in=8'h01 mid-frame -> the old value is shown until the wrap; from the next frame digit 0 shows seg=0111000 with dp=0, and digit 7 shows 0000001.
- data_in=32'h00000050, lz_suppress=1 -> digits 7..2 have seg=1111111, digit 1 shows 0100100, digit 0 shows 0000001; with data_in=0, digit 0 still shows 0000001.
- blank_in=8'h80, data_in=32'h88888888 -> digit 7 seg=1111111, dp=1; all other digits seg=0000000.
- data_load held asserted on the wrap-tick cycle with a new value -> the prior shadow displays for this frame and the new value on the next frame (pending stays set).
- div_val changed 100 -> 2 while cnt=50 -> tick on the next cycle, then a period of 3; Rst during frame 2 -> next cycle an=11111111, frame_done=0, and the display shows zeros after re-load.
